// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32I core.
// Captures decoded operands and main-control outputs at the end of ID,
// detects load-use hazards against the instruction currently in EX,
// inserts a one-cycle bubble on a hazard, squashes on a taken branch/jump
// flush, and keeps saturating stall/flush event counters for debug.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             id_reg_write,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic [1:0]       id_alu_op,

  input  logic             flush,
  input  logic             hold,

  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_reg_write,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [1:0]       ex_alu_op,

  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Pipeline register state
  logic             valid_q,      valid_d;
  logic [XLEN-1:0]  pc_q,         pc_d;
  logic [XLEN-1:0]  rs1_data_q,   rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q,   rs2_data_d;
  logic [XLEN-1:0]  imm_q,        imm_d;
  logic [4:0]       rs1_q,        rs1_d;
  logic [4:0]       rs2_q,        rs2_d;
  logic [4:0]       rd_q,         rd_d;
  logic [2:0]       funct3_q,     funct3_d;
  logic             funct7b5_q,   funct7b5_d;
  logic             reg_write_q,  reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             mem_read_q,   mem_read_d;
  logic             mem_write_q,  mem_write_d;
  logic             alu_src_q,    alu_src_d;
  logic             branch_q,     branch_d;
  logic             jump_q,       jump_d;
  logic [1:0]       alu_op_q,     alu_op_d;

  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  logic             uses_rs1;
  logic             uses_rs2;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             bubble;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Hazard detection: a load in EX whose destination feeds a source the ID
  // instruction actually reads. Jumps read no register; stores read rs2
  // even though they use the immediate as the ALU operand.
  always_comb begin
    uses_rs1 = ~id_jump;
    uses_rs2 = (~id_alu_src & ~id_jump) | id_mem_write;
    rs1_hit  = uses_rs1 & (rd_q == id_rs1);
    rs2_hit  = uses_rs2 & (rd_q == id_rs2);
    load_use = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid & (rs1_hit | rs2_hit);
    // A flush kills the ID instruction, so a hazard against it is moot.
    stall    = hold | (load_use & ~flush);
    bubble   = flush | load_use;
  end

  // Next-state selection: hold freezes, flush/load-use bubble, else load from ID
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    funct7b5_d   = funct7b5_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    alu_src_d    = alu_src_q;
    branch_d     = branch_q;
    jump_d       = jump_q;
    alu_op_d     = alu_op_q;

    if (!hold) begin
      if (bubble) begin
        valid_d      = 1'b0;
        pc_d         = '0;
        rs1_data_d   = '0;
        rs2_data_d   = '0;
        imm_d        = '0;
        rs1_d        = '0;
        rs2_d        = '0;
        rd_d         = '0;
        funct3_d     = '0;
        funct7b5_d   = 1'b0;
        reg_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        alu_src_d    = 1'b0;
        branch_d     = 1'b0;
        jump_d       = 1'b0;
        alu_op_d     = '0;
      end else begin
        valid_d      = id_valid;
        pc_d         = id_pc;
        rs1_data_d   = id_rs1_data;
        rs2_data_d   = id_rs2_data;
        imm_d        = id_imm;
        rs1_d        = id_rs1;
        rs2_d        = id_rs2;
        rd_d         = id_rd;
        funct3_d     = id_funct3;
        funct7b5_d   = id_funct7b5;
        reg_write_d  = id_reg_write;
        mem_to_reg_d = id_mem_to_reg;
        mem_read_d   = id_mem_read;
        mem_write_d  = id_mem_write;
        alu_src_d    = id_alu_src;
        branch_d     = id_branch;
        jump_d       = id_jump;
        alu_op_d     = id_alu_op;
      end
    end
  end

  // Saturating event counters; flush takes precedence over load-use
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!hold) begin
      if (flush) begin
        if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + 1'b1;
      end else if (load_use) begin
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      funct7b5_q   <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      branch_q     <= 1'b0;
      jump_q       <= 1'b0;
      alu_op_q     <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      funct7b5_q   <= funct7b5_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      branch_q     <= branch_d;
      jump_q       <= jump_d;
      alu_op_q     <= alu_op_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = pc_q;
  assign ex_rs1_data   = rs1_data_q;
  assign ex_rs2_data   = rs2_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs1        = rs1_q;
  assign ex_rs2        = rs2_q;
  assign ex_rd         = rd_q;
  assign ex_funct3     = funct3_q;
  assign ex_funct7b5   = funct7b5_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_to_reg = mem_to_reg_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_mem_write  = mem_write_q;
  assign ex_alu_src    = alu_src_q;
  assign ex_branch     = branch_q;
  assign ex_jump       = jump_q;
  assign ex_alu_op     = alu_op_q;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (CNT_W = 2 so saturation is reachable).
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [2:0]       id_funct3;
  logic             id_funct7b5, id_reg_write, id_mem_to_reg, id_mem_read;
  logic             id_mem_write, id_alu_src, id_branch, id_jump;
  logic [1:0]       id_alu_op;
  logic             flush, hold;

  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [2:0]       ex_funct3;
  logic             ex_funct7b5, ex_reg_write, ex_mem_to_reg, ex_mem_read;
  logic             ex_mem_write, ex_alu_src, ex_branch, ex_jump;
  logic [1:0]       ex_alu_op;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_reg_write(id_reg_write),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_branch(id_branch), .id_jump(id_jump), .id_alu_op(id_alu_op),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_op(ex_alu_op),
    .stall(stall), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid = 0; id_pc = '0; id_rs1_data = '0; id_rs2_data = '0; id_imm = '0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7b5 = 0;
    id_reg_write = 0; id_mem_to_reg = 0; id_mem_read = 0; id_mem_write = 0;
    id_alu_src = 0; id_branch = 0; id_jump = 0; id_alu_op = 2'b00;
  endtask

  // lb rd, 0(rs1)
  task automatic drv_lb(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] pc);
    clr_id();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1;
    id_mem_read = 1; id_reg_write = 1; id_mem_to_reg = 1; id_alu_src = 1;
    id_alu_op = 2'b00;
  endtask

  // R-type rd, rs1, rs2 (sub when f7b5 = 1)
  task automatic drv_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic f7b5, input logic [31:0] pc);
    clr_id();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_reg_write = 1; id_alu_src = 0; id_alu_op = 2'b10; id_funct7b5 = f7b5;
  endtask

  // addi rd, rs1, imm
  task automatic drv_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm,
                          input logic [31:0] pc);
    clr_id();
    id_valid = 1; id_pc = pc; id_rd = rd; id_rs1 = rs1; id_imm = imm;
    id_reg_write = 1; id_alu_src = 1; id_alu_op = 2'b11;
  endtask

  initial begin
    clr_id();
    flush = 0; hold = 0; reset = 1;
    id_valid = 1; id_pc = $urandom; id_imm = $urandom; id_rd = 5'($urandom);
    id_mem_read = 1; id_reg_write = 1; id_rs1_data = $urandom;
    tick();
    id_pc = $urandom; id_rd = 5'($urandom); id_jump = 1;
    tick();
    chk("rst_valid", ex_valid, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_rd", ex_rd, 0);
    chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_jump}, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_stall", stall, 0);

    // pass-through addi x6,x1,5
    reset = 0;
    drv_addi(5'd6, 5'd1, 32'd5, 32'h100);
    #1 chk("addi_stall", stall, 0);
    tick();
    chk("addi_rd", ex_rd, 6);
    chk("addi_imm", ex_imm, 5);
    chk("addi_aluop", ex_alu_op, 2'b11);
    chk("addi_valid", ex_valid, 1);
    chk("addi_pc", ex_pc, 32'h100);

    // load-use via rs2: lb x5 ; sub x7,x1,x5
    drv_lb(5'd5, 5'd1, 32'h104);
    #1 chk("lb_stall", stall, 0);
    tick();
    chk("lb_memrd", ex_mem_read, 1);
    drv_r(5'd7, 5'd1, 5'd5, 1'b1, 32'h108);
    #1 chk("lu_stall", stall, 1);
    tick();
    chk("lu_bub_valid", ex_valid, 0);
    chk("lu_bub_rw", ex_reg_write, 0);
    chk("lu_bub_rd", ex_rd, 0);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_stall_drop", stall, 0);
    tick();
    chk("sub_rd", ex_rd, 7);
    chk("sub_f7", ex_funct7b5, 1);
    chk("sub_valid", ex_valid, 1);
    chk("sub_pc", ex_pc, 32'h108);

    // lb x0 then add x3,x0,x0: no stall
    drv_lb(5'd0, 5'd1, 32'h10c);
    tick();
    drv_r(5'd3, 5'd0, 5'd0, 1'b0, 32'h110);
    #1 chk("x0_stall", stall, 0);
    tick();
    chk("x0_add_rd", ex_rd, 3);

    // lb x5 then jal with rs1 field = 5: no stall
    drv_lb(5'd5, 5'd1, 32'h114);
    tick();
    clr_id();
    id_valid = 1; id_jump = 1; id_rs1 = 5; id_rs2 = 5; id_rd = 1; id_pc = 32'h118;
    #1 chk("jmp_stall", stall, 0);
    tick();
    chk("jmp_ex_jump", ex_jump, 1);
    chk("jmp_valid", ex_valid, 1);
    chk("jmp_stall_cnt", stall_cnt, 1);

    // flush coincident with load-use
    drv_lb(5'd5, 5'd1, 32'h11c);
    tick();
    drv_r(5'd7, 5'd5, 5'd2, 1'b0, 32'h120);
    flush = 1;
    #1 chk("fl_stall", stall, 0);
    tick();
    flush = 0;
    chk("fl_valid", ex_valid, 0);
    chk("fl_flush_cnt", flush_cnt, 1);
    chk("fl_stall_cnt", stall_cnt, 1);

    // hold for 3 cycles with changing ID, flush ignored while held
    drv_addi(5'd6, 5'd1, 32'd9, 32'h200);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drv_r(5'(10 + i), 5'd2, 5'd3, 1'b0, 32'h300 + 32'(i));
      flush = (i == 1);
      #1 chk("hold_stall", stall, 1);
      tick();
      chk("hold_rd", ex_rd, 6);
      chk("hold_pc", ex_pc, 32'h200);
    end
    chk("hold_flush_cnt", flush_cnt, 1);
    hold = 0; flush = 0;

    // back-to-back loads, dependent third: one bubble only
    drv_lb(5'd5, 5'd1, 32'h400);
    tick();
    drv_lb(5'd6, 5'd8, 32'h404);
    #1 chk("b2b_no_stall", stall, 0);
    tick();
    drv_r(5'd9, 5'd6, 5'd5, 1'b0, 32'h408);
    #1 chk("b2b_stall", stall, 1);
    tick();
    chk("b2b_bubble", ex_valid, 0);
    #1 chk("b2b_stall_drop", stall, 0);
    tick();
    chk("b2b_rd", ex_rd, 9);
    chk("b2b_stall_cnt", stall_cnt, 2);

    // reset mid-stall: everything cleared, no residual bubble
    drv_lb(5'd5, 5'd1, 32'h500);
    tick();
    drv_r(5'd7, 5'd1, 5'd5, 1'b1, 32'h504);
    #1 chk("rms_stall", stall, 1);
    reset = 1;
    tick();
    chk("rms_valid", ex_valid, 0);
    chk("rms_memrd", ex_mem_read, 0);
    chk("rms_cnts", {stall_cnt, flush_cnt}, 0);
    reset = 0;
    #1 chk("rms_stall_after", stall, 0);
    tick();
    chk("rms_rd", ex_rd, 7);
    chk("rms_valid2", ex_valid, 1);

    // saturation: four load-use events with CNT_W = 2
    for (int i = 0; i < 4; i++) begin
      drv_lb(5'd5, 5'd1, 32'h600);
      tick();
      drv_r(5'd7, 5'd5, 5'd0, 1'b0, 32'h604);
      tick();
      tick();
    end
    chk("sat_stall_cnt", stall_cnt, 3);
    chk("sat_flush_cnt", flush_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded operands and the main control unit's outputs at the end of ID and presents them to EX. It inserts a one-cycle bubble on a load-use hazard and clears itself on a taken branch or jump flush. It also keeps saturating stall and flush counters for debug.

## Interface
- XLEN, 32, datapath width (pc, register data, immediate)
- CNT_W, 16, width of the performance counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock; all state updates on rising edge of clk
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  ID datapath values
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  instruction bit 30
- id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_alu_src, id_branch, id_jump  in  1 each  control unit outputs
- id_alu_op  in  2  control unit ALUOp (00 ld/st, 01 branch, 10 R, 11 I)
- flush  in  1  EX resolved taken branch/jump; squash the ID instruction
- hold  in  1  global freeze (memory busy)
- ex_* (one per id_* input above, same widths), ex_valid  out  registered ID/EX contents
- stall  out  1  freeze PC and IF/ID this cycle (combinational)
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Source-use derivation from the decoded controls:
  - uses_rs1 = ~id_jump
  - uses_rs2 = (~id_alu_src & ~id_jump) | id_mem_write
  - This covers R-type, branch and store using rs2, and jump using no sources.
- load_use = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((uses_rs1 & ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2)).
- stall = hold | (load_use & ~flush).
- Register update, in priority order:
  1. reset: all ex_* outputs, ex_valid and both counters go to 0.
  2. hold: every register keeps its value; counters unchanged.
  3. flush: all ex_* and ex_valid are cleared (bubble); flush_cnt += 1. This applies even if load_use is true.
  4. load_use: all ex_* and ex_valid are cleared (bubble); stall_cnt += 1.
  5. Otherwise: every ex_* loads its id_* value, and ex_valid <= id_valid.
- A bubble is all-zero: no reg_write, mem_read, mem_write, branch or jump; rd = 0.
- If id_valid = 0 and no higher-priority case applies, the register loads normally, so ex_valid becomes 0.
- Counters saturate at 2^CNT_W - 1 and never wrap.
- flush is honoured only when hold = 0. EX keeps flush asserted across a hold, since EX is frozen too.

## Timing
- Latency is 1 cycle: id_* sampled at edge N appear on ex_* after edge N.
- stall is a combinational function of the current ex_* registers and id_* inputs, valid in the same cycle.
- A load-use stall lasts exactly one cycle:
  - After the bubble, ex_mem_read = 0, so load_use drops.
  - The held ID instruction then advances on the next edge.
- Back-to-back loads with a dependent third instruction give one bubble only, before the third instruction.
- Reset value of every output is 0; stall reads 0 while reset is asserted with hold = 0.
- Reset asserted mid-stall or mid-hold clears everything on that edge. There is no residual bubble afterwards.
- A flush coincident with load_use: stall = 0 and flush_cnt increments; stall_cnt does not.

## Test plan
- Reset: drive random id_* with reset = 1 for 2 cycles -> all ex_* = 0, ex_valid = 0, stall_cnt = flush_cnt = 0.
- Pass-through: addi x6,x1,5 (id_alu_op = 11, id_imm = 5, id_rd = 6) with no hazard -> next cycle ex_rd = 6, ex_imm = 5, ex_alu_op = 11, ex_valid = 1, stall = 0.
- Load-use, rs2 path:
  - Stimulus: lb x5 in EX, then sub x7,x1,x5 in ID.
  - Required: stall = 1 for one cycle, then a bubble in EX (ex_valid = 0, ex_reg_write = 0), stall_cnt = 1, and sub in EX on the following cycle.
- No false stall:
  - lb x0 then add x3,x0,x0 -> stall = 0.
  - lb x5 then j (id_jump = 1, id_rs1 field = 5) -> stall = 0.
- Flush vs load-use: load_use condition true and flush = 1 in the same cycle -> stall = 0, ex_valid = 0 next cycle, flush_cnt = 1, stall_cnt unchanged.
- Hold and saturation:
  - hold = 1 for 3 cycles with changing id_* -> ex_* frozen and stall = 1 throughout.
  - With CNT_W = 2, four load-use events -> stall_cnt stays at 3.
